hamming_secded_pipe: RTL and testbench

//  Parametrised, pipelined SECDED decoder for the Program 2 codeword layout. Replaces the per-half 16-entry

---
 rtl/ecc_pkg.sv | 46 ++++
 rtl/ecc_syndrome_calc.sv | 17 +
 rtl/hamming_secded_pipe.sv | 142 ++++++++++++++
 tb/tb_hamming_secded_pipe.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared SECDED types and helpers for the Hamming codeword layout (bit i = position i, bit 0 = p0).
package ecc_pkg;

  typedef enum logic [1:0] {
    CLEAN = 2'b00,
    SEC   = 2'b01,
    DED   = 2'b10,
    P0ERR = 2'b11
  } ecc_status_t;

  localparam int ECC_R  = 4;
  localparam int ECC_N  = 2**ECC_R;
  localparam int ECC_DW = ECC_N - ECC_R - 1;

  // Helpers work on a maximum-size word so any R up to MAX_R shares one implementation.
  localparam int MAX_R = 8;
  localparam int MAX_N = 2**MAX_R;

  function automatic logic [MAX_R-1:0] syndrome(input logic [MAX_N-1:0] cw, input int r);
    logic [MAX_R-1:0] s;
    s = '0;
    for (int i = 1; i < MAX_N; i++) begin
      if (i < (1 << r)) begin
        for (int k = 0; k < MAX_R; k++) begin
          if (i[k]) s[k] = s[k] ^ cw[i];
        end
      end
    end
    return s;
  endfunction

  function automatic logic [MAX_N-1:0] extract_data(input logic [MAX_N-1:0] cw, input int r);
    logic [MAX_N-1:0] d;
    int j;
    d = '0;
    j = 0;
    for (int i = 1; i < MAX_N; i++) begin
      if (i < (1 << r) && (i & (i - 1)) != 0) begin
        d[j] = cw[i];
        j++;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/ecc_syndrome_calc.sv
// Combinational Hamming syndrome and overall parity of one codeword.
module ecc_syndrome_calc
  import ecc_pkg::*;
#(
  parameter int R = 4
) (
  input  logic [2**R-1:0] cw,
  output logic [R-1:0]    syn,
  output logic            par
);

  localparam int CW_EXT = MAX_N;

  assign syn = R'(syndrome(CW_EXT'(cw), R));
  assign par = ^cw;

endmodule

// File: rtl/hamming_secded_pipe.sv
// Two-stage SECDED decoder: S1 registers syndrome/parity, S2 classifies, corrects and extracts.
// Both stages advance together; a stalled output freezes the whole pipe.
module hamming_secded_pipe
  import ecc_pkg::*;
#(
  parameter int R     = 4,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2**R-1:0]     in_cw,
  input  logic                correct_en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2**R-R-2:0]   out_data,
  output ecc_status_t         out_status,
  input  logic                cnt_clr,
  output logic [CNT_W-1:0]    sec_cnt,
  output logic [CNT_W-1:0]    ded_cnt
);

  localparam int N      = 2**R;
  localparam int DW     = N - R - 1;
  localparam int CW_EXT = MAX_N;

  logic             v1_q, v1_d, v2_q, v2_d;
  logic [N-1:0]     cw1_q, cw1_d;
  logic             ce1_q, ce1_d;
  logic [R-1:0]     syn1_q, syn1_d;
  logic             par1_q, par1_d;
  logic [DW-1:0]    data_q, data_d;
  ecc_status_t      status_q, status_d;
  logic [CNT_W-1:0] sec_cnt_q, sec_cnt_d, ded_cnt_q, ded_cnt_d;

  logic [R-1:0]     syn_c;
  logic             par_c;
  logic             stage_en;
  logic             xfer;
  ecc_status_t      class_c;
  logic [N-1:0]     cw_fix;

  ecc_syndrome_calc #(.R(R)) u_syn (
    .cw  (in_cw),
    .syn (syn_c),
    .par (par_c)
  );

  assign stage_en = !v2_q || out_ready;
  assign xfer     = v2_q && out_ready;

  always_comb begin
    v1_d   = v1_q;
    cw1_d  = cw1_q;
    ce1_d  = ce1_q;
    syn1_d = syn1_q;
    par1_d = par1_q;
    if (stage_en) begin
      v1_d = in_valid;
      if (in_valid) begin
        cw1_d  = in_cw;
        ce1_d  = correct_en;
        syn1_d = syn_c;
        par1_d = par_c;
      end
    end
  end

  // Only a SEC word with correction enabled gets a bit flipped; DED data stays raw.
  always_comb begin
    class_c = CLEAN;
    cw_fix  = cw1_q;
    if (syn1_q == '0) begin
      class_c = par1_q ? P0ERR : CLEAN;
    end else if (par1_q) begin
      class_c = SEC;
      if (ce1_q) cw_fix = cw1_q ^ ({{(N-1){1'b0}}, 1'b1} << syn1_q);
    end else begin
      class_c = DED;
    end
  end

  always_comb begin
    v2_d     = v2_q;
    data_d   = data_q;
    status_d = status_q;
    if (stage_en) begin
      v2_d = v1_q;
      if (v1_q) begin
        data_d   = DW'(extract_data(CW_EXT'(cw_fix), R));
        status_d = class_c;
      end
    end
  end

  always_comb begin
    sec_cnt_d = sec_cnt_q;
    ded_cnt_d = ded_cnt_q;
    if (cnt_clr) begin
      sec_cnt_d = '0;
      ded_cnt_d = '0;
    end else if (xfer) begin
      if ((status_q == SEC || status_q == P0ERR) && sec_cnt_q != '1) sec_cnt_d = sec_cnt_q + 1'b1;
      if (status_q == DED && ded_cnt_q != '1) ded_cnt_d = ded_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      cw1_q     <= '0;
      ce1_q     <= 1'b0;
      syn1_q    <= '0;
      par1_q    <= 1'b0;
      data_q    <= '0;
      status_q  <= CLEAN;
      sec_cnt_q <= '0;
      ded_cnt_q <= '0;
    end else begin
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      cw1_q     <= cw1_d;
      ce1_q     <= ce1_d;
      syn1_q    <= syn1_d;
      par1_q    <= par1_d;
      data_q    <= data_d;
      status_q  <= status_d;
      sec_cnt_q <= sec_cnt_d;
      ded_cnt_q <= ded_cnt_d;
    end
  end

  assign in_ready   = stage_en;
  assign out_valid  = v2_q;
  assign out_data   = data_q;
  assign out_status = status_q;
  assign sec_cnt    = sec_cnt_q;
  assign ded_cnt    = ded_cnt_q;

endmodule

// File: tb/tb_hamming_secded_pipe.sv
// Directed-vector bench for hamming_secded_pipe at R=4, CNT_W=8.
module tb_hamming_secded_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_cw;
  logic        correct_en;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_data;
  logic [1:0]  out_status;
  logic        cnt_clr;
  logic [7:0]  sec_cnt;
  logic [7:0]  ded_cnt;

  int n_vec = 0;
  int n_err = 0;
  int exp_sec = 0;
  int exp_ded = 0;

  always #5 clk = ~clk;

  hamming_secded_pipe #(.R(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_cw      (in_cw),
    .correct_en (correct_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_status (out_status),
    .cnt_clr    (cnt_clr),
    .sec_cnt    (sec_cnt),
    .ded_cnt    (ded_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_sec_cnt"}, 32'(sec_cnt), 32'(exp_sec));
    chk({tag, "_ded_cnt"}, 32'(ded_cnt), 32'(exp_ded));
  endtask

  // One word through an idle pipe with out_ready high; checks latency, result and counters.
  task automatic xfer(input string tag, input logic [15:0] cw, input logic ce,
                      input logic [10:0] ed, input logic [1:0] es);
    @(negedge clk);
    in_cw = cw; correct_en = ce; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(ed));
    chk({tag, "_status"}, 32'(out_status), 32'(es));
    @(negedge clk);
    if (es == 2'b01 || es == 2'b11) exp_sec = (exp_sec == 255) ? 255 : exp_sec + 1;
    if (es == 2'b10) exp_ded = (exp_ded == 255) ? 255 : exp_ded + 1;
    check_counters(tag);
    chk({tag, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  logic [15:0] s_cw   [8];
  logic [10:0] s_data [8];

  initial begin
    int idx, oidx;
    rst_n = 1'b0; in_valid = 1'b0; in_cw = '0; correct_en = 1'b1;
    out_ready = 1'b1; cnt_clr = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_status", 32'(out_status), 32'd0);
    check_counters("rst");
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    xfer("t1_zero", 16'h0000, 1'b1, 11'h000, 2'b00);
    xfer("t1_valid_cw", 16'h000F, 1'b1, 11'h001, 2'b00);
    xfer("t2_sec13", 16'h2000, 1'b1, 11'h000, 2'b01);
    xfer("t2_sec13_raw", 16'h2000, 1'b0, 11'h100, 2'b01);
    xfer("t2_sec13_data", 16'h200F, 1'b1, 11'h001, 2'b01);
    xfer("t2_sec_parity4", 16'h0010, 1'b1, 11'h000, 2'b01);
    xfer("t3_ded", 16'h2001, 1'b1, 11'h100, 2'b10);
    xfer("t3_ded_2data", 16'h0028, 1'b1, 11'h003, 2'b10);
    xfer("t3_p0err", 16'h0001, 1'b1, 11'h000, 2'b11);

    // Stream of single-bit data positions, detect-only so each returns a distinct data bit.
    s_cw   = '{16'h0008, 16'h0020, 16'h0040, 16'h0080, 16'h0200, 16'h0400, 16'h0800, 16'h1000};
    s_data = '{11'h001, 11'h002, 11'h004, 11'h008, 11'h010, 11'h020, 11'h040, 11'h080};
    idx = 0; oidx = 0;
    correct_en = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c <= 5);
      in_valid  = (idx < 8);
      in_cw     = (idx < 8) ? s_cw[idx] : 16'h0000;
      #1;
      if (out_valid && !out_ready) chk("t4_in_ready_full", 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
        if (oidx < 8) begin
          chk($sformatf("t4_data%0d", oidx), 32'(out_data), 32'(s_data[oidx]));
          chk($sformatf("t4_status%0d", oidx), 32'(out_status), 32'd1);
        end
        oidx++;
        exp_sec++;
      end
      if (in_valid && in_ready) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1; correct_en = 1'b1;
    chk("t4_out_count", 32'(oidx), 32'd8);
    @(negedge clk);
    check_counters("t4");

    // Saturation: clear, then 255 SEC words, then one more.
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    exp_sec = 0; exp_ded = 0;
    check_counters("t5_clr");
    for (int i = 0; i < 255; i++) begin
      in_valid = 1'b1; in_cw = 16'h2000;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    exp_sec = 255;
    check_counters("t5_255");
    xfer("t5_sat", 16'h2000, 1'b1, 11'h000, 2'b01);
    in_valid = 1'b1; in_cw = 16'h2000;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t5_clr_pending_valid", 32'(out_valid), 32'd1);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    exp_sec = 0;
    check_counters("t5_clr_prio");

    // Fill both stages while stalled, then reset.
    xfer("t6_pre", 16'h0020, 1'b1, 11'h000, 2'b01);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_cw = 16'h2001;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("t6_full_valid", 32'(out_valid), 32'd1);
    chk("t6_full_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_status", 32'(out_status), 32'd0);
    exp_sec = 0; exp_ded = 0;
    check_counters("t6_rst");
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("t6_no_replay", 32'(out_valid), 32'd0);
    xfer("t6_post", 16'h200F, 1'b1, 11'h001, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
